// File: rtl/idct_mac_unit.sv
// ---------------------------------------------------------------------------
// idct_mac_unit
//
// One output lane of a 1-D 8-point inverse DCT. Eight dequantised
// coefficients F(0..7) arrive in order, one per handshake, and the unit
// produces the single spatial sample
//    x[X] = sum_u K[u] * F(u),  K[u] = round(4096 * c(u)/2 * cos((2X+1)u*pi/16))
// scaled back by 2^12 with round-half-up. Eight instances (X = 0..7) make a
// full pass; LEVEL_SHIFT=1 adds 128 and clamps to 0..255 for the final
// column pass.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both high. valid never depends on ready on the same side, out_data is
// held stable while out_valid && !out_ready, and in_ready only drops while
// the output is stalled.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   in_valid   coefficient valid
//   in_ready   unit can accept a coefficient
//   in_data    F(u), signed COEF_W; u comes from the internal counter
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   x[X], signed OUT_W (0..255 zero-extended when LEVEL_SHIFT=1)
// ---------------------------------------------------------------------------
module idct_mac_unit #(
   parameter int X           = 0,
   parameter int COEF_W      = 12,
   parameter int CONST_W     = 13,
   parameter int ACC_W       = 28,
   parameter int OUT_W       = 16,
   parameter int LEVEL_SHIFT = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [COEF_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [OUT_W-1:0]  out_data
);

   localparam int PROD_W = COEF_W + CONST_W;

   localparam logic signed [ACC_W-1:0] OUT_MAX =
      ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

   // Constant for coefficient index u. The cosine argument (2X+1)u*pi/16 is
   // folded into the first quadrant: k and 32-k share a cosine, and k and
   // 16-k have cosines of opposite sign. The first-quadrant magnitudes are
   // round(2048*cos(m*pi/16)); u=0 carries the extra 1/sqrt(2) (1448).
   function automatic logic signed [CONST_W-1:0] k_of(input logic [2:0] u);
      int   k;
      int   m;
      int   mag;
      logic neg;
      if (u == 3'd0) begin
         return CONST_W'(1448);
      end
      k = ((2 * X + 1) * int'(u)) % 32;
      if (k > 16) begin
         k = 32 - k;
      end
      neg = (k > 8);
      m   = neg ? (16 - k) : k;
      case (m)
         0:       mag = 2048;
         1:       mag = 2009;
         2:       mag = 1892;
         3:       mag = 1703;
         4:       mag = 1448;
         5:       mag = 1138;
         6:       mag = 784;
         7:       mag = 400;
         default: mag = 0;
      endcase
      return neg ? CONST_W'(-mag) : CONST_W'(mag);
   endfunction

   // Coefficient counter and handshake
   logic [2:0] cnt;
   logic       stall;
   logic       accept;

   // Stage 1: product register
   logic signed [CONST_W-1:0] k_cur;
   logic signed [PROD_W-1:0]  prod_c;
   logic signed [PROD_W-1:0]  p_prod;
   logic                      p_vld;
   logic                      p_first;
   logic                      p_last;

   // Stage 2: accumulator and result shaping
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] sum_c;
   logic signed [ACC_W-1:0] rnd_c;
   logic signed [ACC_W-1:0] shf_c;
   logic signed [OUT_W-1:0] res_c;

   // A result that nobody has taken freezes the whole pipe.
   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;
   assign accept   = in_valid && in_ready;

   always_comb begin
      k_cur  = k_of(cnt);
      prod_c = PROD_W'(in_data) * PROD_W'(k_cur);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= 3'd0;
      end else if (accept) begin
         cnt <= cnt + 3'd1;   // wraps 7 -> 0
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_vld   <= 1'b0;
         p_prod  <= '0;
         p_first <= 1'b0;
         p_last  <= 1'b0;
      end else if (!stall) begin
         p_vld <= accept;
         if (accept) begin
            p_prod  <= prod_c;
            p_first <= (cnt == 3'd0);
            p_last  <= (cnt == 3'd7);
         end
      end
   end

   // u=0 restarts the sum, so a new block never sees the previous total.
   always_comb begin
      sum_c = p_first ? ACC_W'(p_prod) : (acc + ACC_W'(p_prod));
      rnd_c = (sum_c + ACC_W'(2048)) >>> 12;
      shf_c = rnd_c + ACC_W'(128);
      res_c = '0;
      if (LEVEL_SHIFT != 0) begin
         if (shf_c[ACC_W-1]) begin
            res_c = '0;
         end else if (shf_c > ACC_W'(255)) begin
            res_c = OUT_W'(255);
         end else begin
            res_c = {{(OUT_W-8){1'b0}}, shf_c[7:0]};
         end
      end else begin
         if (rnd_c > OUT_MAX) begin
            res_c = OUT_MAX[OUT_W-1:0];
         end else if (rnd_c < OUT_MIN) begin
            res_c = OUT_MIN[OUT_W-1:0];
         end else begin
            res_c = rnd_c[OUT_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (!stall) begin
         if (p_vld) begin
            acc <= sum_c;
         end
         // A freshly finished block replaces the result being accepted now.
         if (p_vld && p_last) begin
            out_valid <= 1'b1;
            out_data  <= res_c;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_idct_mac_unit.sv
// ---------------------------------------------------------------------------
// tb_idct_mac_unit
//
// Sixteen instances share one input stream and one out_ready: X = 0..7 with
// LEVEL_SHIFT=0 (index 0..7) and X = 0..7 with LEVEL_SHIFT=1 (index 8..15).
// They run in lockstep, so instance 0 drives the handshake bookkeeping and
// every instance's out_data is checked against a floating-point reference
// of the transform with the rounding and clamp rules applied.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_idct_mac_unit;

   localparam int  NI            = 16;
   localparam int  N_RAND_BLOCKS = 1500;
   localparam real PI            = 3.14159265358979323846;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic [11:0]      in_data;
   logic             out_ready;
   logic [NI-1:0]    in_ready_v;
   logic [NI-1:0]    out_valid_v;
   logic [15:0]      out_data_v [NI];

   int n_cmp  = 0;
   int n_fail = 0;

   // Expected results of every block, 16 bits per instance.
   logic [NI*16-1:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      idct_mac_unit #(
         .X           (g % 8),
         .LEVEL_SHIFT (g / 8)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (in_ready_v[g]),
         .in_data   (in_data),
         .out_valid (out_valid_v[g]),
         .out_ready (out_ready),
         .out_data  (out_data_v[g])
      );
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int ref_out(input int x, input int ls, input logic [95:0] f);
      longint sum = 0;
      longint r;
      real    cu;
      real    v;
      int     k;
      for (int u = 0; u < 8; u++) begin
         cu = (u == 0) ? 1.0 / $sqrt(2.0) : 1.0;
         v  = 4096.0 * cu / 2.0 * $cos(real'((2 * x + 1) * u) * PI / 16.0);
         k  = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
         sum += longint'(k) * longint'($signed(f[u*12 +: 12]));
      end
      r = (sum + 2048) >>> 12;
      if (ls != 0) begin
         r = r + 128;
         if (r < 0)   r = 0;
         if (r > 255) r = 255;
      end else begin
         if (r > 32767)  r = 32767;
         if (r < -32768) r = -32768;
      end
      return int'(r);
   endfunction

   function automatic logic [NI*16-1:0] model_block(input logic [95:0] f);
      logic [NI*16-1:0] e;
      e = '0;
      for (int g = 0; g < NI; g++) begin
         e[g*16 +: 16] = 16'(ref_out(g % 8, g / 8, f));
      end
      return e;
   endfunction

   function automatic logic [95:0] rand_block();
      logic [95:0] f;
      for (int u = 0; u < 8; u++) begin
         f[u*12 +: 12] = 12'($urandom_range(0, 4095));
      end
      return f;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Present one coefficient until it is taken; returns just after the
   // accepting edge with in_valid low.
   task automatic drive_coef(input logic [11:0] f);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = f;
      @(negedge clk);
      while (!in_ready_v[0] && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready_v[0]) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drive_timeout: in_ready got 0, expected 1 within 200 cycles");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drive_block(input logic [95:0] f);
      for (int u = 0; u < 8; u++) begin
         drive_coef(f[u*12 +: 12]);
      end
   endtask

   // Returns on the falling edge where out_valid is seen, if within budget.
   task automatic wait_out(input int max_cyc, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (out_valid_v[0]) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (out_valid_v !== '0) begin
         n_fail++;
         $display("FAIL reset_out_valid: got %h expected 0000", out_valid_v);
      end
      n_cmp++;
      if (in_ready_v !== '1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %h expected ffff", in_ready_v);
      end
      for (int g = 0; g < NI; g++) begin
         n_cmp++;
         if (out_data_v[g] !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_out_data[%0d]: got %h expected 0000", g, out_data_v[g]);
         end
      end
      cyc();
      rst = 1'b1;
      cyc();
   endtask

   task automatic test_single_dc();
      out_ready = 1'b1;
      drive_block(96'd64);
      // Now in the cycle after the last accept (T+1).
      @(negedge clk);
      n_cmp++;
      if (out_valid_v[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL dc_early_valid: got %b expected 0 at T+1", out_valid_v[0]);
      end
      cyc();
      @(negedge clk);
      n_cmp++;
      if (out_valid_v[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL dc_latency: out_valid got %b expected 1 at T+2", out_valid_v[0]);
      end
      n_cmp++;
      if (out_data_v[0] !== 16'd23) begin
         n_fail++;
         $display("FAIL dc_data: got %0d expected 23", $signed(out_data_v[0]));
      end
      cyc();
      @(negedge clk);
      n_cmp++;
      if (out_valid_v[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL dc_one_cycle: out_valid got %b expected 0 at T+3", out_valid_v[0]);
      end
      cyc();
   endtask

   task automatic test_level_shift();
      bit seen;
      out_ready = 1'b1;
      drive_block(96'd1024);
      wait_out(10, seen);
      n_cmp++;
      if (!seen || out_data_v[11] !== 16'd255) begin
         n_fail++;
         $display("FAIL ls_high_clamp: got %0d (seen %b) expected 255", out_data_v[11], seen);
      end
      cyc();
      drive_block({84'd0, 12'hC00});
      wait_out(10, seen);
      n_cmp++;
      if (!seen || out_data_v[11] !== 16'd0) begin
         n_fail++;
         $display("FAIL ls_low_clamp: got %0d (seen %b) expected 0", out_data_v[11], seen);
      end
      cyc();
   endtask

   task automatic test_back_to_back();
      logic [95:0]      fa;
      logic [95:0]      fb;
      logic [NI*16-1:0] e;
      logic             exp_v;
      fa = rand_block();
      fb = rand_block();
      exp_q.delete();
      exp_q.push_back(model_block(fa));
      exp_q.push_back(model_block(fb));
      out_ready = 1'b1;
      for (int c = 0; c < 22; c++) begin
         in_valid = (c < 16);
         if (c < 8)       in_data = fa[c*12 +: 12];
         else if (c < 16) in_data = fb[(c-8)*12 +: 12];
         @(negedge clk);
         if (c < 16) begin
            n_cmp++;
            if (in_ready_v[0] !== 1'b1) begin
               n_fail++;
               $display("FAIL b2b_in_ready c=%0d: got %b expected 1", c, in_ready_v[0]);
            end
         end
         exp_v = (c == 9) || (c == 17);
         n_cmp++;
         if (out_valid_v[0] !== exp_v) begin
            n_fail++;
            $display("FAIL b2b_out_valid c=%0d: got %b expected %b", c, out_valid_v[0], exp_v);
         end
         if (out_valid_v[0] && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int g = 0; g < NI; g++) begin
               n_cmp++;
               if (out_data_v[g] !== e[g*16 +: 16]) begin
                  n_fail++;
                  $display("FAIL b2b_data[%0d] c=%0d: got %h expected %h", g, c, out_data_v[g], e[g*16 +: 16]);
               end
            end
         end
         cyc();
      end
      in_valid = 1'b0;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_results: %0d results missing, expected 0", exp_q.size());
      end
   endtask

   task automatic test_stall();
      logic [95:0]      fa;
      logic [95:0]      fb;
      logic [NI*16-1:0] ea;
      logic [NI*16-1:0] eb;
      bit               seen;
      fa = rand_block();
      fb = rand_block();
      ea = model_block(fa);
      eb = model_block(fb);
      out_ready = 1'b1;
      drive_block(fa);
      out_ready = 1'b0;
      // Taken in the cycle before A's result appears; must survive the stall.
      drive_coef(fb[11:0]);
      in_valid = 1'b1;
      in_data  = fb[23:12];
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_cmp++;
         if (in_ready_v[0] !== 1'b0 || out_valid_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_flags k=%0d: in_ready %b out_valid %b, expected 0 and 1", k, in_ready_v[0], out_valid_v[0]);
         end
         n_cmp++;
         if (out_data_v[0] !== ea[15:0] || out_data_v[11] !== ea[11*16 +: 16]) begin
            n_fail++;
            $display("FAIL stall_hold k=%0d: got %h/%h expected %h/%h", k, out_data_v[0], out_data_v[11], ea[15:0], ea[11*16 +: 16]);
         end
         cyc();
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (in_ready_v[0] !== 1'b1 || out_data_v[0] !== ea[15:0]) begin
         n_fail++;
         $display("FAIL stall_release: in_ready %b data %h, expected 1 and %h", in_ready_v[0], out_data_v[0], ea[15:0]);
      end
      cyc();
      in_valid = 1'b0;
      for (int u = 2; u < 8; u++) begin
         drive_coef(fb[u*12 +: 12]);
      end
      wait_out(10, seen);
      n_cmp++;
      if (!seen) begin
         n_fail++;
         $display("FAIL stall_next_timeout: out_valid got 0, expected 1 within 10 cycles");
      end
      for (int g = 0; g < NI; g++) begin
         n_cmp++;
         if (out_data_v[g] !== eb[g*16 +: 16]) begin
            n_fail++;
            $display("FAIL stall_next_data[%0d]: got %h expected %h", g, out_data_v[g], eb[g*16 +: 16]);
         end
      end
      cyc();
   endtask

   task automatic test_reset_mid_block();
      logic [95:0] f;
      bit          seen;
      f = rand_block();
      out_ready = 1'b1;
      for (int u = 0; u < 4; u++) begin
         drive_coef(f[u*12 +: 12]);
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if (out_valid_v !== '0 || in_ready_v !== '1) begin
         n_fail++;
         $display("FAIL midrst_async: out_valid %h in_ready %h, expected 0000 and ffff", out_valid_v, in_ready_v);
      end
      cyc();
      rst = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_no_output k=%0d: out_valid got %b expected 0", k, out_valid_v[0]);
         end
         cyc();
      end
      drive_block(96'd64);
      wait_out(10, seen);
      n_cmp++;
      if (!seen || out_data_v[0] !== 16'd23) begin
         n_fail++;
         $display("FAIL midrst_dc: got %0d (seen %b) expected 23", $signed(out_data_v[0]), seen);
      end
      cyc();
   endtask

   task automatic test_random();
      logic [95:0]      cur;
      logic [NI*16-1:0] e;
      int               nc;
      int               blocks;
      int               cyc_n;
      logic             held;
      logic [15:0]      held_data;
      cur       = '0;
      nc        = 0;
      blocks    = 0;
      cyc_n     = 0;
      held      = 1'b0;
      held_data = '0;
      exp_q.delete();
      while ((blocks < N_RAND_BLOCKS || exp_q.size() != 0) && cyc_n < 60000) begin
         in_valid  = (blocks < N_RAND_BLOCKS) && ($urandom_range(0, 3) != 0);
         in_data   = 12'($urandom_range(0, 4095));
         out_ready = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         if (held) begin
            n_cmp++;
            if (out_valid_v[0] !== 1'b1 || out_data_v[0] !== held_data) begin
               n_fail++;
               $display("FAIL rand_hold cyc=%0d: valid %b data %h, expected 1 and %h", cyc_n, out_valid_v[0], out_data_v[0], held_data);
            end
         end
         if (in_valid && in_ready_v[0]) begin
            cur[nc*12 +: 12] = in_data;
            nc++;
            if (nc == 8) begin
               exp_q.push_back(model_block(cur));
               nc = 0;
               blocks++;
            end
         end
         if (out_valid_v[0] && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL rand_spurious cyc=%0d: out_valid got 1 expected 0 (no block pending)", cyc_n);
            end else begin
               e = exp_q.pop_front();
               for (int g = 0; g < NI; g++) begin
                  n_cmp++;
                  if (out_data_v[g] !== e[g*16 +: 16]) begin
                     n_fail++;
                     $display("FAIL rand_data[%0d] cyc=%0d: got %h expected %h", g, cyc_n, out_data_v[g], e[g*16 +: 16]);
                  end
               end
            end
         end
         held      = out_valid_v[0] && !out_ready;
         held_data = out_data_v[0];
         cyc_n++;
         cyc();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n_cmp++;
      if (exp_q.size() != 0 || blocks != N_RAND_BLOCKS) begin
         n_fail++;
         $display("FAIL rand_drain: %0d pending, %0d blocks sent, expected 0 pending and %0d blocks", exp_q.size(), blocks, N_RAND_BLOCKS);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single_dc();
      test_level_shift();
      test_back_to_back();
      test_stall();
      test_reset_mid_block();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
